// File: rtl/fir_structs.sv
// Shared types for the complex FIR filter and its input feeder.
// Samples are signed 1.23, coefficients signed 3.24, both as I/Q pairs.
package fir_structs;

    localparam int NUM_COEF  = 15;
    localparam int BUF_DEPTH = 2;

    typedef struct packed {
        logic signed [23:0] I;
        logic signed [23:0] Q;
    } Samp;

    typedef struct packed {
        logic signed [26:0] I;
        logic signed [26:0] Q;
    } Coef;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD,
        ST_GAP,
        ST_STREAM
    } feed_state_e;

endpackage

// File: rtl/firc_samp_buf.sv
// Small sample FIFO between the upstream source and the firc PushIn port.
// Head is combinational from the read pointer; count is registered.
module firc_samp_buf
    import fir_structs::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  Samp                        i_data,
    output Samp                        o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    Samp           r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= f_inc(r_wr);
            end
            if (i_pop) r_rd <= f_inc(r_rd);
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/firc_feeder.sv
// Drives firc: replays the shadow coefficient bank as a PushCoef burst,
// then streams buffered upstream samples onto PushIn under StopIn.
module firc_feeder #(
    parameter int NUM_COEF  = 15,
    parameter int BUF_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CfgWe,
    input  logic [4:0]  CfgAddr,
    input  logic [26:0] CfgI,
    input  logic [26:0] CfgQ,
    input  logic        CfgLoad,
    input  logic        SrcValid,
    output logic        SrcReady,
    input  logic [23:0] SrcI,
    input  logic [23:0] SrcQ,
    output logic        PushIn,
    input  logic        StopIn,
    output logic [23:0] SampI,
    output logic [23:0] SampQ,
    output logic        PushCoef,
    output logic [4:0]  CoefAddr,
    output logic [26:0] CoefI,
    output logic [26:0] CoefQ,
    output logic        Busy,
    output logic        CoefDone
);

    import fir_structs::*;

    localparam int AW = $clog2(NUM_COEF + 1);
    localparam int SN = 1 << AW;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    feed_state_e   r_state;
    feed_state_e   w_next;
    Coef           r_shadow [SN];
    logic [4:0]    r_cnt;
    logic          r_done;
    logic [CW-1:0] w_count;
    Samp           w_head;
    Samp           w_src;
    Coef           w_coef;
    logic          w_we;
    logic          w_push;
    logic          w_empty;
    logic          w_last;

    // Entry 0 is never written, so index 0 always reads back zero.
    assign w_we = CfgWe
               && (r_state == ST_IDLE || r_state == ST_STREAM)
               && (CfgAddr != 5'd0)
               && (CfgAddr <= 5'(NUM_COEF));

    assign w_coef  = r_shadow[r_cnt[AW-1:0]];
    assign w_last  = (r_cnt == 5'(NUM_COEF));
    assign w_empty = (w_count == '0);
    assign w_src   = {SrcI, SrcQ};
    assign w_push  = SrcValid & SrcReady;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < SN; i++) r_shadow[i] <= '0;
        end else if (w_we) begin
            r_shadow[CfgAddr[AW-1:0]] <= {CfgI, CfgQ};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_next == ST_LOAD)
                r_cnt <= (r_state == ST_LOAD) ? r_cnt + 5'd1 : 5'd1;
            else
                r_cnt <= '0;
            if (r_state == ST_GAP) r_done <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (CfgLoad) w_next = ST_LOAD;
            ST_DRAIN:  if (w_empty) w_next = ST_LOAD;
            ST_LOAD:   if (w_last)  w_next = ST_GAP;
            ST_GAP:    w_next = ST_STREAM;
            ST_STREAM: if (CfgLoad) w_next = ST_DRAIN;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        SrcReady = 1'b0;
        PushIn   = 1'b0;
        PushCoef = 1'b0;
        CoefAddr = '0;
        CoefI    = '0;
        CoefQ    = '0;
        Busy     = 1'b0;
        unique case (r_state)
            ST_DRAIN: begin
                Busy   = 1'b1;
                PushIn = !w_empty && !StopIn;
            end
            ST_LOAD: begin
                Busy     = 1'b1;
                PushCoef = 1'b1;
                CoefAddr = r_cnt;
                CoefI    = w_coef.I;
                CoefQ    = w_coef.Q;
            end
            ST_GAP: Busy = 1'b1;
            ST_STREAM: begin
                SrcReady = (w_count < CW'(BUF_DEPTH));
                PushIn   = !w_empty && !StopIn;
            end
            default: ;
        endcase
    end

    assign SampI    = w_empty ? '0 : w_head.I;
    assign SampQ    = w_empty ? '0 : w_head.Q;
    assign CoefDone = r_done | (r_state == ST_GAP);

    firc_samp_buf #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk    (Clk),
        .rst    (Reset),
        .i_push (w_push),
        .i_pop  (PushIn),
        .i_data (w_src),
        .o_head (w_head),
        .o_count(w_count)
    );

endmodule

// File: tb/tb_firc_feeder.sv
// Scoreboard bench for firc_feeder: a shadow-bank model predicts bursts,
// a queue of accepted samples predicts the buffer head and push order.
module tb_firc_feeder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CfgWe;
    logic [4:0]  CfgAddr;
    logic [26:0] CfgI;
    logic [26:0] CfgQ;
    logic        CfgLoad;
    logic        SrcValid;
    logic        SrcReady;
    logic [23:0] SrcI;
    logic [23:0] SrcQ;
    logic        PushIn;
    logic        StopIn;
    logic [23:0] SampI;
    logic [23:0] SampQ;
    logic        PushCoef;
    logic [4:0]  CoefAddr;
    logic [26:0] CoefI;
    logic [26:0] CoefQ;
    logic        Busy;
    logic        CoefDone;

    firc_feeder #(
        .NUM_COEF (15),
        .BUF_DEPTH(2)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .CfgWe   (CfgWe),
        .CfgAddr (CfgAddr),
        .CfgI    (CfgI),
        .CfgQ    (CfgQ),
        .CfgLoad (CfgLoad),
        .SrcValid(SrcValid),
        .SrcReady(SrcReady),
        .SrcI    (SrcI),
        .SrcQ    (SrcQ),
        .PushIn  (PushIn),
        .StopIn  (StopIn),
        .SampI   (SampI),
        .SampQ   (SampQ),
        .PushCoef(PushCoef),
        .CoefAddr(CoefAddr),
        .CoefI   (CoefI),
        .CoefQ   (CoefQ),
        .Busy    (Busy),
        .CoefDone(CoefDone)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  a;
        logic [26:0] i;
        logic [26:0] q;
    } coef_t;

    typedef struct {
        logic [23:0] i;
        logic [23:0] q;
    } samp_t;

    coef_t       cq[$];
    samp_t       sq[$];
    logic [26:0] sh_i [16];
    logic [26:0] sh_q [16];
    bit          open;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_write(input int a, input logic [26:0] i,
                               input logic [26:0] q);
        if (open && a >= 1 && a <= 15) begin
            sh_i[a] = i;
            sh_q[a] = q;
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 16; n++) begin
            sh_i[n] = '0;
            sh_q[n] = '0;
        end
        cq.delete();
        sq.delete();
    endtask

    task automatic model_load();
        for (int n = 1; n <= 15; n++)
            cq.push_back('{a: 5'(n), i: sh_i[n], q: sh_q[n]});
    endtask

    always @(negedge Clk) begin : mon
        coef_t ce;
        samp_t se;
        if (!Reset) begin
            if (PushCoef) begin
                if (cq.size() == 0) begin
                    chk("coef_unexpected", 64'(PushCoef), 64'd0);
                end else begin
                    ce = cq.pop_front();
                    chk("coef_addr", 64'(CoefAddr), 64'(ce.a));
                    chk("coef_data", 64'({CoefI, CoefQ}), 64'({ce.i, ce.q}));
                end
            end else begin
                chk("coef_idle", 64'({CoefAddr, CoefI, CoefQ}), 64'd0);
            end
            if (PushIn) begin
                if (sq.size() == 0) begin
                    chk("samp_unexpected", 64'(PushIn), 64'd0);
                end else begin
                    se = sq.pop_front();
                    chk("samp_data", 64'({SampI, SampQ}), 64'({se.i, se.q}));
                end
            end else if (sq.size() == 0) begin
                chk("samp_idle_zero", 64'({SampI, SampQ}), 64'd0);
            end else begin
                chk("samp_idle_head", 64'({SampI, SampQ}),
                    64'({sq[0].i, sq[0].q}));
            end
            if (StopIn) chk("stop_blocks_push", 64'(PushIn), 64'd0);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [26:0] i, input logic [26:0] q);
        CfgWe   = 1'b1;
        CfgAddr = 5'(a);
        CfgI    = i;
        CfgQ    = q;
        @(posedge Clk);
        model_write(a, i, q);
        #1;
        CfgWe = 1'b0;
    endtask

    task automatic load(input bit from_idle, input int we_addr,
                        input int reset_at);
        int w = 0;
        CfgLoad = 1'b1;
        if (we_addr != 0) begin
            CfgWe   = 1'b1;
            CfgAddr = 5'(we_addr);
            CfgI    = 27'($urandom);
            CfgQ    = 27'($urandom);
            model_write(we_addr, CfgI, CfgQ);
        end
        model_load();
        tick();
        CfgLoad = 1'b0;
        CfgWe   = 1'b0;
        open    = 1'b0;
        while (!PushCoef && w < 10) begin
            chk("drain_ready", 64'(SrcReady), 64'd0);
            chk("drain_busy", 64'(Busy), 64'd1);
            CfgWe   = (w == 0);
            CfgAddr = 5'd2;
            CfgI    = 27'($urandom);
            CfgQ    = 27'($urandom);
            if (w == 1) StopIn = 1'b0;
            tick();
            w++;
        end
        CfgWe    = 1'b0;
        StopIn   = 1'b0;
        SrcValid = 1'b0;
        if (from_idle) chk("load_latency", 64'(w), 64'd0);
        chk("burst_start", 64'(PushCoef), 64'd1);
        for (int j = 1; j <= 15; j++) begin
            if (j == reset_at) begin
                chk("rst_at_addr", 64'(CoefAddr), 64'(j));
                Reset = 1'b1;
                #1;
                chk("rst_mid_ctl",
                    64'({SrcReady, PushIn, PushCoef, Busy, CoefDone}), 64'd0);
                chk("rst_mid_coef", 64'({CoefAddr, CoefI, CoefQ}), 64'd0);
                chk("rst_mid_samp", 64'({SampI, SampQ}), 64'd0);
                model_reset();
                open = 1'b1;
                tick();
                Reset = 1'b0;
                tick();
                return;
            end
            chk("load_flags", 64'({PushCoef, Busy, SrcReady}), 64'b110);
            CfgWe   = (j == 5);
            CfgAddr = 5'd3;
            CfgI    = 27'($urandom);
            CfgQ    = 27'($urandom);
            tick();
        end
        CfgWe = 1'b0;
        chk("gap_flags", 64'({PushCoef, Busy, SrcReady, CoefDone}), 64'b0101);
        tick();
        chk("stream_flags", 64'({PushCoef, Busy, SrcReady, CoefDone}), 64'b0011);
        open = 1'b1;
    endtask

    task automatic stream(input int n, input int base, input int stop_at,
                          input int stop_len);
        int sent = 0;
        int cyc  = 0;
        bit take;
        while (sent < n && cyc < 2000) begin
            SrcValid = 1'b1;
            SrcI     = 24'(base + sent);
            SrcQ     = -SrcI;
            StopIn   = (cyc >= stop_at) && (cyc < stop_at + stop_len);
            @(negedge Clk);
            if (cyc >= 1 && !StopIn) chk("push_every_cycle", 64'(PushIn), 64'd1);
            if (stop_len > 0 && cyc > stop_at && cyc < stop_at + stop_len)
                chk("stall_ready", 64'(SrcReady), 64'd0);
            take = SrcReady;
            @(posedge Clk);
            if (take) begin
                sq.push_back('{i: SrcI, q: SrcQ});
                sent++;
            end
            #1;
            cyc++;
        end
        SrcValid = 1'b0;
        StopIn   = 1'b0;
        chk("stream_sent", 64'(sent), 64'(n));
    endtask

    task automatic drain();
        int c = 0;
        StopIn   = 1'b0;
        SrcValid = 1'b0;
        while (sq.size() != 0 && c < 20) begin
            tick();
            c++;
        end
        chk("drain_empty", 64'(sq.size()), 64'd0);
    endtask

    task automatic fill2();
        int c = 0;
        StopIn   = 1'b1;
        SrcValid = 1'b1;
        while (SrcReady && c < 10) begin
            SrcI = 24'($urandom);
            SrcQ = 24'($urandom);
            @(posedge Clk);
            sq.push_back('{i: SrcI, q: SrcQ});
            #1;
            c++;
        end
        chk("fill_count", 64'(sq.size()), 64'd2);
    endtask

    task automatic random_run(input int cycles);
        bit take;
        bit wrt;
        for (int c = 0; c < cycles; c++) begin
            SrcValid = ($urandom_range(0, 9) < 7);
            SrcI     = 24'($urandom);
            SrcQ     = 24'($urandom);
            StopIn   = ($urandom_range(0, 9) < 3);
            CfgWe    = ($urandom_range(0, 9) < 2);
            CfgAddr  = 5'($urandom_range(0, 31));
            CfgI     = 27'($urandom);
            CfgQ     = 27'($urandom);
            @(negedge Clk);
            take = SrcValid && SrcReady;
            wrt  = CfgWe;
            @(posedge Clk);
            if (take) sq.push_back('{i: SrcI, q: SrcQ});
            if (wrt) model_write(int'(CfgAddr), CfgI, CfgQ);
            #1;
        end
        CfgWe = 1'b0;
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        CfgWe    = 1'b0;
        CfgAddr  = '0;
        CfgI     = '0;
        CfgQ     = '0;
        CfgLoad  = 1'b0;
        SrcValid = 1'b0;
        SrcI     = '0;
        SrcQ     = '0;
        StopIn   = 1'b0;
        open     = 1'b1;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_ctl", 64'({SrcReady, PushIn, PushCoef, Busy, CoefDone}), 64'd0);
        chk("rst_coef", 64'({CoefAddr, CoefI, CoefQ}), 64'd0);
        chk("rst_samp", 64'({SampI, SampQ}), 64'd0);
        Reset = 1'b0;
        tick();
        chk("idle_flags", 64'({SrcReady, Busy, CoefDone}), 64'd0);

        for (int n = 1; n <= 15; n++) wr(n, 27'(n), 27'(-n));
        wr(0, 27'd777, 27'd777);
        wr(20, 27'd555, 27'd555);
        load(1'b1, 0, 0);

        stream(100, 1, 0, 0);
        drain();
        stream(20, 200, 6, 5);
        drain();

        fill2();
        load(1'b0, 9, 0);

        random_run(300);
        load(1'b0, 0, 0);
        stream(10, 300, 3, 2);
        drain();

        load(1'b0, 0, 7);
        chk("idle_after_rst", 64'({SrcReady, Busy, CoefDone}), 64'd0);
        load(1'b1, 0, 0);
        stream(5, 1000, 0, 0);
        drain();
        chk("coef_queue_empty", 64'(cq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/firc_feeder.md
# firc_feeder

Input-side driver for the complex FIR filter `firc`. Holds a shadow bank of 15 complex coefficients written by the host, replays it onto the filter's coefficient port as a burst of consecutive `PushCoef` cycles, then streams complex samples from an upstream valid/ready source onto the filter's `PushIn`/`StopIn` port. Sits between the host/sample source and `firc`. It is the transmitter end of the `firc` sample and coefficient interface.

## Interface
Parameters:
- NUM_COEF, 15, coefficient entries; `CoefAddr` runs 1..NUM_COEF.
- BUF_DEPTH, 2, sample buffer entries.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- CfgWe  in  1  write shadow coefficient.
- CfgAddr  in  5  shadow address. Valid range 1..15; 0 and 16..31 are ignored.
- CfgI, CfgQ  in  27 each  signed 3.24 coefficient.
- CfgLoad  in  1  single-cycle request to transmit the shadow bank.
- SrcValid  in  1  upstream sample valid.
- SrcReady  out  1  upstream sample ready.
- SrcI, SrcQ  in  24 each  signed 1.23 sample.
- PushIn  out  1  to `firc.PushIn`.
- StopIn  in  1  from `firc.StopIn`.
- SampI, SampQ  out  24 each  to `firc`.
- PushCoef  out  1  to `firc`.
- CoefAddr  out  5  to `firc`.
- CoefI, CoefQ  out  27 each  to `firc`.
- Busy  out  1  high in DRAIN, LOAD or GAP.
- CoefDone  out  1  high once any load has completed. Cleared only by reset.

## Operation
- **States:** IDLE, DRAIN, LOAD, GAP, STREAM. Reset enters IDLE.
- **IDLE:**
  - `CfgLoad` moves to LOAD.
  - Samples are not accepted (`SrcReady`=0).
- **LOAD:**
  - The counter runs 1..15, one entry per cycle.
  - `PushCoef`=1, `CoefAddr`=counter, `CoefI`/`CoefQ`=shadow[counter].
  - After entry 15 the block moves to GAP.
  - `StopIn` is ignored, because the coefficient port has no backpressure.
- **GAP:**
  - One cycle with `PushCoef`=0, so that `firc` sees `!PushCoef` before the first `PushIn`.
  - `CoefDone` is set.
  - Moves to STREAM.
- **STREAM:**
  - `SrcReady` = (buffer count < BUF_DEPTH).
  - A sample is accepted on `SrcValid&SrcReady` and enters the FIFO.
  - `PushIn` = buffer non-empty & !`StopIn`. This is combinational from `StopIn` and the registered count.
  - `SampI`/`SampQ` = buffer head.
  - The buffer pops on `PushIn`.
  - `CfgLoad` moves to DRAIN.
- **DRAIN:**
  - `SrcReady`=0.
  - Buffered samples keep draining under `StopIn`.
  - Moves to LOAD when the buffer is empty; if it is already empty, LOAD follows on the next cycle.
- **Shadow writes:**
  - `CfgWe` writes only in IDLE or STREAM.
  - Writes in DRAIN, LOAD or GAP are dropped.
  - `CfgWe` and `CfgLoad` in the same cycle: the write lands, and the burst carries the new value.
- `CfgLoad` in DRAIN, LOAD or GAP is ignored.
- **Idle values:** when `PushCoef`=0, `CoefAddr`/`CoefI`/`CoefQ` are 0. When `PushIn`=0, `SampI`/`SampQ` hold the buffer head, or 0 if the buffer is empty.
- There is no arithmetic; data passes bit-exact.
- **Reset mid-operation:** every register clears immediately, including the shadow bank (zeros), buffer, counter and `CoefDone`. Any burst or stream in progress is abandoned.

## Timing
- **Reset values:** all outputs 0.
- **Load burst:** `CfgLoad` sampled at edge k in IDLE →
  - `PushCoef`=1 during cycles k+1..k+15, `CoefAddr` 1..15;
  - GAP at k+16;
  - `SrcReady`=1 from k+17;
  - `Busy` high k+1..k+16.
- **Sample latency:** a sample accepted at edge m appears with `PushIn`=1 in cycle m+1 if `StopIn`=0.
- **Throughput:** one sample per cycle sustained.
- **StopIn stall:**
  - `StopIn`=1 forces `PushIn`=0 in the same cycle.
  - The buffer fills to 2 and `SrcReady` drops one cycle later.
  - No sample is lost or duplicated.
  - `PushIn` resumes in the cycle `StopIn` falls.

## Structure
- **Shared package, `fir_structs`:**
  - `Samp` typedef {I,Q: 24-bit}.
  - `Coef` typedef {I,Q: 27-bit}.
  - `NUM_COEF`.
  - Feeder state enum.
- **Sub-module `firc_samp_buf`:** 2-entry `Samp` FIFO with push, pop, count, head, and asynchronous reset.
- Shadow bank, FSM and load counter live in `firc_feeder`.

## Test plan
- **Coefficient burst:** write shadow[n] = {I=n, Q=-n} for n=1..15, then pulse `CfgLoad` → 15 consecutive `PushCoef` cycles with `CoefAddr` 1..15 and matching data, one GAP cycle, `CoefDone`=1.
- **Ignored writes:** a `CfgWe` to addr 0 or addr 20, and a `CfgWe` during LOAD → shadow unchanged; the next burst replays the old values.
- **Streaming:** stream samples I=1..100, Q=-I with `SrcValid` held and `StopIn`=0 → 100 `PushIn` cycles back-to-back, order preserved, first push one cycle after first accept.
- **StopIn backpressure:** assert `StopIn` for 5 cycles mid-stream → `PushIn`=0 immediately, `SrcReady`=0 after the buffer fills; output sequence has no gaps or repeats.
- **Reload from STREAM:** `CfgLoad` during STREAM with 2 samples buffered → both samples pushed, then the 15-cycle burst; `SrcReady` low throughout DRAIN, LOAD and GAP.
- **Reset mid-burst:** `Reset` asserted at `CoefAddr`=7 → all outputs 0 in the same cycle; state IDLE; shadow bank reads back zeros on the next load.
